fb_port_arbiter: RTL and testbench

- Schedules burst accesses to the single shared frame-buffer memory port between two requesters.
- Camera write path: drains the camera write FIFO into memory.
- Display read path: prefetches pixels into the display read FIFO ahead of the VGA sync generator's active region.
- Generates all burst addresses itself, restarts each address stream on its own frame boundary, and guarantees display reads are never starved.

---
 rtl/fb_port_if.sv | 26 ++
 rtl/fb_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_if.sv
// Burst command / completion bus between the frame-buffer arbiter and the memory controller.
interface fb_port_if #(
    parameter int ADDR_W = 21
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic              mem_done;

    modport master (
        output cmd_valid,
        output cmd_wr,
        output cmd_addr,
        input  cmd_ready,
        input  mem_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_wr,
        input  cmd_addr,
        output cmd_ready,
        output mem_done
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Shares one frame-buffer memory port between camera write bursts and display read prefetch.
// Optional double-buffered frame store is enabled by defining FB_BANK_SWAP_EN.
module fb_port_arbiter #(
    parameter int ADDR_W        = 21,
    parameter int LVL_W         = 10,
    parameter int BURST_LEN     = 8,
    parameter int FRAME_WORDS   = 480000,
    parameter int RD_FIFO_DEPTH = 512,
    parameter int RD_LOW        = 64
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             disp_vsync,
    input  logic             cam_frame_start,
    input  logic [LVL_W-1:0] wr_level,
    input  logic [LVL_W-1:0] rd_level,
    fb_port_if.master        mem,
    output logic             busy,
    output logic             rd_underrun
);

    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t            state_q, state_d;
    logic              grant_wr, grant_rd, accept;
    logic              last_wr;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              vsync_q, vsync_fall, rd_en;
    logic              wr_pend, rd_pend, rd_urgent;
    int                rd_free;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] n;
        n = p + BURST_A;
        return (n == FRAME_A) ? '0 : n;
    endfunction

    assign vsync_fall = vsync_q & ~disp_vsync;
    assign rd_free    = RD_FIFO_DEPTH - int'(rd_level);
    assign wr_pend    = int'(wr_level) >= BURST_LEN;
    assign rd_pend    = rd_en && (rd_free >= BURST_LEN);
    assign rd_urgent  = rd_pend && (int'(rd_level) < RD_LOW);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Arbitration only in IDLE; alternation breaks ties, urgency overrides it.
    always_comb begin
        state_d  = state_q;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_urgent || (rd_pend && (!wr_pend || last_wr))) grant_rd = 1'b1;
                else if (wr_pend)                                    grant_wr = 1'b1;
                if (grant_rd || grant_wr) state_d = CMD;
            end
            CMD: begin
                if (mem.cmd_ready) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.cmd_valid = (state_q == CMD);
    assign mem.cmd_wr    = cmd_wr_q;
    assign mem.cmd_addr  = cmd_addr_q;
    assign busy          = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= '0;
            last_wr    <= 1'b1;
        end else if (grant_wr || grant_rd) begin
            cmd_wr_q   <= grant_wr;
            cmd_addr_q <= grant_wr ? wr_addr : rd_addr;
            last_wr    <= grant_wr;
        end
    end

    // Frame restarts win over a same-cycle pointer advance.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (cam_frame_start)        wr_ptr <= '0;
            else if (accept && cmd_wr_q) wr_ptr <= ptr_next(wr_ptr);
            if (vsync_fall)              rd_ptr <= '0;
            else if (accept && !cmd_wr_q) rd_ptr <= ptr_next(rd_ptr);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vsync_q     <= 1'b0;
            rd_en       <= 1'b0;
            rd_underrun <= 1'b0;
        end else begin
            vsync_q <= disp_vsync;
            if (vsync_fall) rd_en <= 1'b1;
            if (rd_en && (rd_level == '0) && disp_vsync) rd_underrun <= 1'b1;
        end
    end

`ifdef FB_BANK_SWAP_EN
    logic wr_bank, done_bank, rd_bank, wr_wrapped, wr_wrap_now;

    assign wr_wrap_now = accept && cmd_wr_q && (ptr_next(wr_ptr) == '0);

    // A bank is only handed to the display once the camera has written it end to end.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_bank    <= 1'b0;
            done_bank  <= 1'b1;
            rd_bank    <= 1'b1;
            wr_wrapped <= 1'b0;
        end else begin
            if (cam_frame_start) begin
                wr_bank    <= ~wr_bank;
                wr_wrapped <= 1'b0;
                if (wr_wrapped || wr_wrap_now) done_bank <= wr_bank;
            end else if (wr_wrap_now) begin
                wr_wrapped <= 1'b1;
            end
            if (vsync_fall) rd_bank <= done_bank;
        end
    end

    assign wr_addr = {wr_bank, wr_ptr[ADDR_W-2:0]};
    assign rd_addr = {rd_bank, rd_ptr[ADDR_W-2:0]};
`else
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a small frame so address wrap is reachable.
module tb_fb_port_arbiter;
    localparam int ADDR_W        = 21;
    localparam int LVL_W         = 10;
    localparam int BURST_LEN     = 8;
    localparam int FRAME_WORDS   = 64;
    localparam int RD_FIFO_DEPTH = 512;
    localparam int RD_LOW        = 64;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             disp_vsync = 1'b1;
    logic             cam_frame_start = 1'b0;
    logic [LVL_W-1:0] wr_level = '0;
    logic [LVL_W-1:0] rd_level = '0;
    logic             busy, rd_underrun;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W:0]   exp_q[$];
    logic [ADDR_W-1:0] wr_exp = '0;
    logic [ADDR_W-1:0] rd_exp = '0;

    fb_port_if #(.ADDR_W(ADDR_W)) mem_if ();

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .LVL_W(LVL_W), .BURST_LEN(BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS), .RD_FIFO_DEPTH(RD_FIFO_DEPTH), .RD_LOW(RD_LOW)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .disp_vsync(disp_vsync),
        .cam_frame_start(cam_frame_start),
        .wr_level(wr_level),
        .rd_level(rd_level),
        .mem(mem_if.master),
        .busy(busy),
        .rd_underrun(rd_underrun)
    );

    always #5 CLK = ~CLK;

    function automatic logic [ADDR_W-1:0] model_next(input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] n;
        n = p + ADDR_W'(BURST_LEN);
        if (n == ADDR_W'(FRAME_WORDS)) n = '0;
        return n;
    endfunction

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_if.cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    // Acts as the memory controller for one burst: accept, then complete.
    task automatic serve(output bit ok, output logic [ADDR_W:0] got);
        wait_valid(ok);
        got = {mem_if.cmd_wr, mem_if.cmd_addr};
        if (!ok) return;
        mem_if.cmd_ready = 1'b1;
        @(negedge CLK);
        mem_if.cmd_ready = 1'b0;
        mem_if.mem_done  = 1'b1;
        @(negedge CLK);
        mem_if.mem_done  = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if (mem_if.cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%b want=0", mem_if.cmd_valid); end
        total++; if (mem_if.cmd_wr !== 1'b0) begin bad++; $display("FAIL reset_cmd_wr got=%b want=0", mem_if.cmd_wr); end
        total++; if (mem_if.cmd_addr !== '0) begin bad++; $display("FAIL reset_cmd_addr got=%h want=0", mem_if.cmd_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rd_underrun !== 1'b0) begin bad++; $display("FAIL reset_rd_underrun got=%b want=0", rd_underrun); end
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write_basic();
        bit ok; logic [ADDR_W:0] got, e;
        wr_level = 10'd8;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b1, wr_exp});
            wr_exp = model_next(wr_exp);
            serve(ok, got);
            e = exp_q.pop_front();
            total++; if (!ok || got !== e) begin bad++; $display("FAIL write_basic[%0d] ok=%b got=%h want=%h", i, ok, got, e); end
        end
        wr_level = '0;
        repeat (2) @(negedge CLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_wrap();
        bit ok; logic [ADDR_W:0] got, e;
        cam_frame_start = 1'b1;
        @(negedge CLK);
        cam_frame_start = 1'b0;
        wr_exp = '0;
        wr_level = 10'd8;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({1'b1, wr_exp});
            wr_exp = model_next(wr_exp);
            serve(ok, got);
            e = exp_q.pop_front();
            total++; if (!ok || got !== e) begin bad++; $display("FAIL wrap[%0d] ok=%b got=%h want=%h", i, ok, got, e); end
        end
        wr_level = '0;
        @(negedge CLK);
    endtask

    task automatic test_read_urgency();
        bit ok; logic [ADDR_W:0] got, e;
        rd_level   = 10'd10;
        disp_vsync = 1'b0;
        @(negedge CLK);
        rd_exp     = '0;
        disp_vsync = 1'b1;
        wr_level   = 10'd8;
        exp_q.push_back({1'b0, rd_exp});
        rd_exp = model_next(rd_exp);
        serve(ok, got);
        e = exp_q.pop_front();
        total++; if (!ok || got !== e) begin bad++; $display("FAIL urgent_read ok=%b got=%h want=%h", ok, got, e); end
        rd_level = 10'd300;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin exp_q.push_back({1'b1, wr_exp}); wr_exp = model_next(wr_exp); end
            else            begin exp_q.push_back({1'b0, rd_exp}); rd_exp = model_next(rd_exp); end
            serve(ok, got);
            e = exp_q.pop_front();
            total++; if (!ok || got !== e) begin bad++; $display("FAIL alternate[%0d] ok=%b got=%h want=%h", i, ok, got, e); end
        end
        wr_level = '0;
        rd_level = 10'd512;
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        bit ok; logic [ADDR_W:0] got, e;
        wr_level = 10'd8;
        e = {1'b1, wr_exp};
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_issue got=timeout want=cmd_valid"); end
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({mem_if.cmd_valid, mem_if.cmd_wr, mem_if.cmd_addr} !== {1'b1, e}) begin
                bad++; $display("FAIL bp_stable[%0d] got=%b/%h want=1/%h", i, mem_if.cmd_valid, {mem_if.cmd_wr, mem_if.cmd_addr}, e);
            end
            mem_if.mem_done = (i == 10);
            @(negedge CLK);
        end
        mem_if.mem_done = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", busy); end
        mem_if.cmd_ready = 1'b1;
        @(negedge CLK);
        mem_if.cmd_ready = 1'b0;
        wr_exp = model_next(wr_exp);
        total++; if (mem_if.cmd_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid got=%b want=0", mem_if.cmd_valid); end
        mem_if.mem_done = 1'b1;
        @(negedge CLK);
        mem_if.mem_done = 1'b0;
        exp_q.push_back({1'b1, wr_exp});
        wr_exp = model_next(wr_exp);
        serve(ok, got);
        e = exp_q.pop_front();
        total++; if (!ok || got !== e) begin bad++; $display("FAIL bp_next ok=%b got=%h want=%h", ok, got, e); end
        wr_level = '0;
        @(negedge CLK);
    endtask

    task automatic test_coincident();
        bit ok; logic [ADDR_W:0] got, e;
        wr_level = 10'd8;
        wait_valid(ok);
        total++; if (!ok || mem_if.cmd_addr !== wr_exp) begin bad++; $display("FAIL coin_first ok=%b got=%h want=%h", ok, mem_if.cmd_addr, wr_exp); end
        mem_if.cmd_ready = 1'b1;
        cam_frame_start  = 1'b1;
        @(negedge CLK);
        mem_if.cmd_ready = 1'b0;
        cam_frame_start  = 1'b0;
        wr_exp = '0;
        mem_if.mem_done = 1'b1;
        @(negedge CLK);
        mem_if.mem_done = 1'b0;
        exp_q.push_back({1'b1, wr_exp});
        wr_exp = model_next(wr_exp);
        serve(ok, got);
        e = exp_q.pop_front();
        total++; if (!ok || got !== e) begin bad++; $display("FAIL coin_restart ok=%b got=%h want=%h", ok, got, e); end
        wr_level = '0;
        @(negedge CLK);
        total++; if (rd_underrun !== 1'b0) begin bad++; $display("FAIL underrun_pre got=%b want=0", rd_underrun); end
        rd_level = '0;
        exp_q.push_back({1'b0, rd_exp});
        rd_exp = model_next(rd_exp);
        @(negedge CLK);
        rd_level = 10'd512;
        total++; if (rd_underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b want=1", rd_underrun); end
        serve(ok, got);
        e = exp_q.pop_front();
        total++; if (!ok || got !== e) begin bad++; $display("FAIL underrun_read ok=%b got=%h want=%h", ok, got, e); end
        repeat (5) @(negedge CLK);
        total++; if (rd_underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b want=1", rd_underrun); end
    endtask

    task automatic test_midreset();
        bit ok;
        wr_level = 10'd8;
        wait_valid(ok);
        mem_if.cmd_ready = 1'b1;
        @(negedge CLK);
        mem_if.cmd_ready = 1'b0;
        wr_level = '0;
        total++; if (!ok || busy !== 1'b1 || mem_if.cmd_valid !== 1'b0) begin bad++; $display("FAIL mid_wait ok=%b busy=%b valid=%b want=1/1/0", ok, busy, mem_if.cmd_valid); end
        #2 RSTn = 1'b0;
        #1;
        total++;
        if ({mem_if.cmd_valid, mem_if.cmd_wr, mem_if.cmd_addr, busy, rd_underrun} !== '0) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%h/%b/%b want=all 0", mem_if.cmd_valid, mem_if.cmd_wr, mem_if.cmd_addr, busy, rd_underrun);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        mem_if.mem_done = 1'b1;
        @(negedge CLK);
        mem_if.mem_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if (mem_if.cmd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stray_done[%0d] valid=%b busy=%b want=0/0", i, mem_if.cmd_valid, busy); end
            @(negedge CLK);
        end
    endtask

    initial begin
        mem_if.cmd_ready = 1'b0;
        mem_if.mem_done  = 1'b0;
        @(negedge CLK);
        test_reset();
        test_write_basic();
        test_wrap();
        test_read_urgency();
        test_backpressure();
        test_coincident();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
